// File: rtl/dmem_wbuf_if.sv
// M-stage data-memory port bundle between the core (master)
// and the write-buffered data memory (slave).
interface dmem_wbuf_if;
  logic        memwriteM;
  logic        memreadM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        wbfull;
  logic        wbempty;
  logic        wberr;

  modport master (
    output memwriteM, memreadM, aluoutM, writedataM,
    input  readdataM, wbfull, wbempty, wberr
  );

  modport slave (
    input  memwriteM, memreadM, aluoutM, writedataM,
    output readdataM, wbfull, wbempty, wberr
  );
endinterface

// File: rtl/dmem_wbuf.sv
// Word SRAM behind a posted write buffer with youngest-match forwarding.
// Optional DMEM_CYCLE_COUNTER_EN maps a cycle counter at 32'hFFFF_FFFC.
module dmem_wbuf #(
  parameter int DEPTH_WORDS = 64,
  parameter int WB_DEPTH    = 4
) (
  input logic       clk,
  input logic       reset,
  dmem_wbuf_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem    [DEPTH_WORDS];
  logic [IW-1:0] wbIdx  [WB_DEPTH];
  logic [31:0]   wbData [WB_DEPTH];

  logic [PW-1:0] head, tail, slot;
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic          full, empty, isCtr;
  logic          push, drop, drain;
  logic          fwdHit;
  logic [31:0]   fwdData, rdata;
  logic          errQ;
  logic [31:0]   unusedBits;

  assign idx   = bus.aluoutM[IW+1:2];
  assign full  = (count == CW'(WB_DEPTH));
  assign empty = (count == '0);
  assign unusedBits = bus.aluoutM;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycleCnt;

  assign isCtr = (bus.aluoutM == 32'hFFFF_FFFC);

  always_ff @(posedge clk) begin
    if (reset) cycleCnt <= '0;
    else       cycleCnt <= cycleCnt + 32'd1;
  end
`else
  assign isCtr = 1'b0;
`endif

  assign push  = !reset && bus.memwriteM && !isCtr && !full;
  assign drop  = bus.memwriteM && !isCtr && full;
  assign drain = !reset && !bus.memreadM
               && !bus.memwriteM && !empty;

  // walk oldest to youngest so the last match wins
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    slot    = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      slot = head + PW'(i);
      if (CW'(i) < count && wbIdx[slot] == idx) begin
        fwdHit  = 1'b1;
        fwdData = wbData[slot];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.memreadM)
      rdata = fwdHit ? fwdData : mem[idx];
`ifdef DMEM_CYCLE_COUNTER_EN
    if (bus.memreadM && isCtr)
      rdata = cycleCnt;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      errQ  <= 1'b0;
    end else begin
      if (push) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end else if (drain) begin
        head  <= head + 1'b1;
        count <= count - 1'b1;
      end
      if (drop) errQ <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wbIdx[tail]  <= idx;
      wbData[tail] <= bus.writedataM;
    end
    if (drain)
      mem[wbIdx[head]] <= wbData[head];
  end

  assign bus.readdataM = rdata;
  assign bus.wbfull    = full;
  assign bus.wbempty   = empty;
  assign bus.wberr     = errQ;
endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed bench for dmem_wbuf: forwarding, drain, overflow,
// aliasing, pointer wrap, mid-stream reset and the cycle counter.
module tb_dmem_wbuf;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  dmem_wbuf_if bus ();

  dmem_wbuf #(
    .DEPTH_WORDS(64),
    .WB_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.memwriteM = 1'b0;
    bus.memreadM  = 1'b0;
    repeat (n) step();
  endtask

  task automatic store(input logic [31:0] a,
                       input logic [31:0] d);
    bus.memwriteM  = 1'b1;
    bus.memreadM   = 1'b0;
    bus.aluoutM    = a;
    bus.writedataM = d;
    step();
    bus.memwriteM  = 1'b0;
  endtask

  task automatic load(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] exp);
    bus.memwriteM = 1'b0;
    bus.memreadM  = 1'b1;
    bus.aluoutM   = a;
    #1;
    check(tag, bus.readdataM, exp);
    step();
    bus.memreadM  = 1'b0;
  endtask

  task automatic status(input string tag,
                        input logic e,
                        input logic f,
                        input logic r);
    check({tag, ".empty"}, 32'(bus.wbempty), 32'(e));
    check({tag, ".full"},  32'(bus.wbfull),  32'(f));
    check({tag, ".err"},   32'(bus.wberr),   32'(r));
  endtask

  initial begin
    bus.memwriteM  = 1'b0;
    bus.memreadM   = 1'b0;
    bus.aluoutM    = '0;
    bus.writedataM = '0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    status("rst", 1'b1, 1'b0, 1'b0);
    check("rst.rdata", bus.readdataM, 32'h0);

    // seed known array contents
    store(32'h0, 32'hA000_0000);
    store(32'h4, 32'hA000_0004);
    store(32'h8, 32'hA000_0008);
    store(32'hC, 32'hA000_000C);
    status("seedfull", 1'b0, 1'b1, 1'b0);
    idle(4);
    store(32'h10, 32'hA000_0010);
    store(32'h20, 32'hA000_0020);
    idle(2);
    status("seeddone", 1'b1, 1'b0, 1'b0);
    load("seed.0x0", 32'h0, 32'hA000_0000);

    // forwarding then drain
    store(32'h10, 32'hDEAD_BEEF);
    bus.memreadM = 1'b1;
    bus.aluoutM  = 32'h10;
    #1;
    check("fwd.empty", 32'(bus.wbempty), 32'h0);
    load("fwd.data", 32'h10, 32'hDEAD_BEEF);
    idle(1);
    check("drain.empty", 32'(bus.wbempty), 32'h1);
    load("drain.data", 32'h10, 32'hDEAD_BEEF);

    // overflow
    store(32'h0, 32'h11);
    store(32'h4, 32'h22);
    store(32'h8, 32'h33);
    store(32'hC, 32'h44);
    status("ovf.full", 1'b0, 1'b1, 1'b0);
    store(32'h20, 32'h55);
    status("ovf.drop", 1'b0, 1'b1, 1'b1);
    load("ovf.0x20", 32'h20, 32'hA000_0020);
    load("ovf.fwd4", 32'h4, 32'h22);
    idle(4);
    status("ovf.drained", 1'b1, 1'b0, 1'b1);
    load("ovf.0x20b", 32'h20, 32'hA000_0020);
    load("ovf.0xC", 32'hC, 32'h44);

    // youngest match with aliasing
    store(32'h4, 32'h1);
    store(32'h104, 32'h2);
    load("alias.fwd", 32'h4, 32'h2);
    idle(2);
    check("alias.empty", 32'(bus.wbempty), 32'h1);
    load("alias.arr", 32'h4, 32'h2);

    // youngest by age across pointer wrap
    store(32'h8, 32'h5);
    store(32'hC, 32'h9);
    store(32'h8, 32'h6);
    store(32'h208, 32'h7);
    load("wrap.fwd8", 32'h8, 32'h7);
    load("wrap.fwdC", 32'hC, 32'h9);
    idle(4);
    load("wrap.arr8", 32'h8, 32'h7);

    // reset with stores pending
    store(32'h0, 32'hAAAA);
    store(32'h10, 32'hBBBB);
    store(32'h20, 32'hCCCC);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    status("midrst", 1'b1, 1'b0, 1'b0);
    load("midrst.0x0", 32'h0, 32'h11);
    load("midrst.0x10", 32'h10, 32'hDEAD_BEEF);
    load("midrst.0x20", 32'h20, 32'hA000_0020);

    // illegal read+write acts as a store, returns old data
    bus.memwriteM  = 1'b1;
    bus.memreadM   = 1'b1;
    bus.aluoutM    = 32'h10;
    bus.writedataM = 32'h1234;
    #1;
    check("rw.old", bus.readdataM, 32'hDEAD_BEEF);
    step();
    bus.memwriteM = 1'b0;
    bus.memreadM  = 1'b0;
    check("rw.push", 32'(bus.wbempty), 32'h0);
    load("rw.new", 32'h10, 32'h1234);
    idle(1);

`ifdef DMEM_CYCLE_COUNTER_EN
    begin
      logic [31:0] v0;
      logic [31:0] v1;
      bus.memreadM = 1'b1;
      bus.aluoutM  = 32'hFFFF_FFFC;
      #1;
      v0 = bus.readdataM;
      step();
      idle(4);
      bus.memreadM = 1'b1;
      bus.aluoutM  = 32'hFFFF_FFFC;
      #1;
      v1 = bus.readdataM;
      step();
      bus.memreadM = 1'b0;
      check("ctr.delta", v1 - v0, 32'd5);
      store(32'hFFFF_FFFC, 32'h77);
      status("ctr.store", 1'b1, 1'b0, 1'b0);
    end
`else
    store(32'hFFFF_FFFC, 32'h77);
    idle(1);
    check("top.empty", 32'(bus.wbempty), 32'h1);
    load("top.alias", 32'hFC, 32'h77);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Data-memory responder for the pipelined core's M-stage memory port: the target end of memwriteM/aluoutM/writedataM/readdataM.
- Models a single-ported word SRAM fronted by a posted write buffer.
- Stores are queued, and drain into the array only on idle cycles. Loads see buffered data through youngest-match forwarding.
- Exports full/empty status so the hazard unit can stall.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of 2).
- WB_DEPTH, 4, write-buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- memwriteM  in  1  store request this cycle
- memreadM  in  1  load request this cycle
- aluoutM  in  32  byte address
- writedataM  in  32  store data
- readdataM  out  32  load data, combinational
- wbfull  out  1  buffer holds WB_DEPTH entries
- wbempty  out  1  buffer holds 0 entries
- wberr  out  1  sticky: a store was dropped

Behaviour:
- Addressing:
  - Word index = aluoutM[log2(DEPTH_WORDS)+1:2]. Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Write buffer:
  - Circular FIFO of {index, data}, with head/tail pointers and a count.
  - Push: memwriteM=1 at an edge pushes {index, writedataM}, provided count<WB_DEPTH.
  - Full: if count==WB_DEPTH the store is dropped, wberr is set to 1, and it stays 1 until reset.
- Drain:
  - On an edge where memreadM=0, memwriteM=0 and count>0, the head entry is written to the array and popped.
  - One entry per idle cycle.
  - No drain on any cycle carrying a load or store, since the array port is single-ported.
- Simultaneous push and drain is impossible by construction: a push cycle is never idle.
- Load (memreadM=1):
  - readdataM = data of the youngest buffered entry whose index matches. If no entry matches, readdataM = array[index].
  - Forwarding scans all valid entries. A store is visible to a load on the cycle after its push edge.
- memreadM=0: readdataM = 32'h0.
- memreadM=1 and memwriteM=1 together (illegal from the core):
  - Treated as a store.
  - readdataM returns the pre-store value; the same-cycle store is not forwarded.
- Status outputs: wbfull = (count==WB_DEPTH); wbempty = (count==0). Both are registered-state derived, so they carry no combinational path from inputs.
- Reset:
  - Sets count, head and tail to 0, and wberr to 0.
  - Outputs after reset: wbempty=1, wbfull=0, readdataM=0 while memreadM=0.
  - Buffered, undrained stores are discarded. This includes reset asserted mid-stream.
  - Array contents are not reset and retain their values.
- Wrap-around: pointers wrap modulo WB_DEPTH. Forwarding remains correct across the wrap, i.e. youngest-first by age, not by slot number.

Optional Feature:
- DMEM_CYCLE_COUNTER_EN defined:
  - Adds a free-running 32-bit cycle counter. It is reset to 0, increments every cycle and wraps at 2^32.
  - A load from full address 32'hFFFF_FFFC returns the counter and bypasses both the buffer and the array.
  - A store to that address is ignored: no push, and wberr is unaffected.
- Not defined: no counter. 32'hFFFF_FFFC aliases into the array like any other address.

Test Plan:
- Forwarding: after reset, store 32'hDEADBEEF to 0x10; next cycle load 0x10 -> readdataM=32'hDEADBEEF, wbempty=0.
- Drain: same sequence plus one idle cycle -> wbempty=1; load 0x10 -> 32'hDEADBEEF, now read from the array.
- Overflow: back-to-back stores to 0x0, 0x4, 0x8, 0xC -> wbfull=1. Store 0x55 to 0x20 -> dropped, wberr=1. Load 0x20 returns the prior array value. Four idle cycles -> wbempty=1, wberr still 1.
- Youngest match and aliasing: store 1 to 0x4, then store 2 to 0x104 (aliases to index 1). Load 0x4 -> 2. After two idle cycles, the array word 1 holds 2.
- Reset mid-operation: three stores pending, then assert reset for 1 cycle -> wbempty=1, wbfull=0, wberr=0. Loads of those addresses return the pre-store array values.
- DMEM_CYCLE_COUNTER_EN: load 32'hFFFF_FFFC on cycle t and again on cycle t+5 -> values differ by exactly 5. A store to that address leaves wbempty=1.
